// File: rtl/sc_stream_decoder.sv
// Stochastic-to-binary converter: skips a programmable number of settling
// cycles, then counts ones over a 2^WIDTH-cycle window and hands the count off.
module sc_stream_decoder #(
    parameter int WIDTH  = 8,
    parameter int SKIP_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [SKIP_W-1:0] skip,
    input  logic              bit_in,
    output logic              busy,
    output logic [WIDTH-1:0]  result,
    output logic              saturated,
    output logic              result_valid,
    input  logic              result_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SKIP = 2'd1,
        ACC  = 2'd2,
        HOLD = 2'd3
    } state_t;

    // 2^WIDTH: both the window length and the only ones count that saturates.
    localparam logic [WIDTH:0] FULL = {1'b1, {WIDTH{1'b0}}};

    state_t            state_reg, state_next;
    logic [SKIP_W-1:0] skip_cnt_reg, skip_cnt_next;
    logic [WIDTH:0]    ones_cnt_reg, ones_cnt_next;
    logic [WIDTH:0]    win_cnt_reg, win_cnt_next;
    logic [WIDTH-1:0]  result_reg, result_next;
    logic              saturated_reg, saturated_next;
    logic              valid_reg, valid_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            skip_cnt_reg  <= '0;
            ones_cnt_reg  <= '0;
            win_cnt_reg   <= '0;
            result_reg    <= '0;
            saturated_reg <= 1'b0;
            valid_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            skip_cnt_reg  <= skip_cnt_next;
            ones_cnt_reg  <= ones_cnt_next;
            win_cnt_reg   <= win_cnt_next;
            result_reg    <= result_next;
            saturated_reg <= saturated_next;
            valid_reg     <= valid_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        skip_cnt_next  = skip_cnt_reg;
        ones_cnt_next  = ones_cnt_reg;
        win_cnt_next   = win_cnt_reg;
        result_next    = result_reg;
        saturated_next = saturated_reg;
        valid_next     = valid_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    skip_cnt_next = skip;
                    ones_cnt_next = '0;
                    win_cnt_next  = '0;
                    state_next    = (skip != '0) ? SKIP : ACC;
                end
            end
            SKIP: begin
                skip_cnt_next = skip_cnt_reg - 1'b1;
                if (skip_cnt_reg == SKIP_W'(1)) begin
                    state_next = ACC;
                end
            end
            ACC: begin
                ones_cnt_next = ones_cnt_reg + {{WIDTH{1'b0}}, bit_in};
                win_cnt_next  = win_cnt_reg + (WIDTH+1)'(1);
                // The edge sampling the last bit of the window publishes the count.
                if (win_cnt_next == FULL) begin
                    result_next    = (ones_cnt_next == FULL) ? {WIDTH{1'b1}}
                                                             : ones_cnt_next[WIDTH-1:0];
                    saturated_next = (ones_cnt_next == FULL);
                    valid_next     = 1'b1;
                    state_next     = HOLD;
                end
            end
            HOLD: begin
                if (result_ready) begin
                    valid_next = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy         = (state_reg != IDLE);
    assign result       = result_reg;
    assign saturated    = saturated_reg;
    assign result_valid = valid_reg;

endmodule

// File: tb/tb_sc_stream_decoder.sv
// Randomized self-checking bench for sc_stream_decoder; expected counts come
// from summing the driven bitstream over the sampled window.
module tb_sc_stream_decoder;

    localparam int WIDTH  = 8;
    localparam int SKIP_W = 4;
    localparam int WIN    = 1 << WIDTH;
    localparam int NSTR   = 512;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [SKIP_W-1:0] skip = '0;
    logic              bit_in = 1'b0;
    logic              busy;
    logic [WIDTH-1:0]  result;
    logic              saturated;
    logic              result_valid;
    logic              result_ready = 1'b0;

    int checks = 0;
    int fails  = 0;

    // stream[k] is the bit presented before the k-th edge after the start edge (k=0 is the start edge)
    bit stream [NSTR];
    logic [WIDTH-1:0] exp_result;
    logic             exp_sat;

    always #5 clk = ~clk;

    sc_stream_decoder #(.WIDTH(WIDTH), .SKIP_W(SKIP_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .skip(skip), .bit_in(bit_in),
        .busy(busy), .result(result), .saturated(saturated),
        .result_valid(result_valid), .result_ready(result_ready)
    );

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Run one conversion with skip s; leaves the DUT in HOLD.
    task automatic convert(input int s, input string name, input bit poke_start);
        int  ones, edges;
        bit  busy_ok;
        ones = 0;
        for (int k = s + 1; k <= s + WIN; k++) ones += int'(stream[k]);
        exp_sat    = (ones == WIN);
        exp_result = exp_sat ? WIDTH'(WIN - 1) : WIDTH'(ones);

        start  = 1'b1;
        skip   = SKIP_W'(s);
        bit_in = stream[0];
        @(posedge clk); #1;
        start   = 1'b0;
        skip    = SKIP_W'($urandom);
        edges   = 0;
        busy_ok = 1'b1;
        while (!result_valid && edges < 400) begin
            edges++;
            bit_in = stream[edges];
            start  = poke_start && (edges == s + 100);
            @(posedge clk); #1;
            start = 1'b0;
            if (!busy) busy_ok = 1'b0;
        end
        checks++;
        if (edges !== s + WIN) begin
            fails++;
            $display("FAIL %s latency: got %0d edges, expected %0d", name, edges, s + WIN);
        end
        checks++;
        if (result !== exp_result) begin
            fails++;
            $display("FAIL %s result: got %0d, expected %0d", name, result, exp_result);
        end
        checks++;
        if (saturated !== exp_sat) begin
            fails++;
            $display("FAIL %s saturated: got %0b, expected %0b", name, saturated, exp_sat);
        end
        checks++;
        if (!busy_ok) begin
            fails++;
            $display("FAIL %s busy: dropped during conversion, expected 1 throughout", name);
        end
        $display("conv %s skip=%0d result=%0d sat=%0b latency=%0d", name, s, result, saturated, edges);
    endtask

    task automatic handshake(input string name, input bit with_start);
        result_ready = 1'b1;
        start        = with_start;
        @(posedge clk); #1;
        result_ready = 1'b0;
        start        = 1'b0;
        checks++;
        if (result_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL %s handshake: valid=%0b busy=%0b, expected 0 0", name, result_valid, busy);
        end
        checks++;
        if (result !== exp_result || saturated !== exp_sat) begin
            fails++;
            $display("FAIL %s retained: result=%0d sat=%0b, expected %0d %0b",
                     name, result, saturated, exp_result, exp_sat);
        end
        $display("handshake %s valid=%0b busy=%0b", name, result_valid, busy);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            checks++;
            if (busy !== 1'b0 || result !== '0 || result_valid !== 1'b0 || saturated !== 1'b0) begin
                fails++;
                $display("FAIL reset cycle %0d: busy=%0b result=%0d valid=%0b sat=%0b, expected all 0",
                         i, busy, result, result_valid, saturated);
            end
        end
        $display("reset idle check done");
    endtask

    task automatic test_all_ones();
        for (int k = 0; k < NSTR; k++) stream[k] = 1'b1;
        convert(0, "all_ones", 1'b0);
        checks++;
        if (result !== 8'd255 || saturated !== 1'b1) begin
            fails++;
            $display("FAIL all_ones literal: result=%0d sat=%0b, expected 255 1", result, saturated);
        end
        handshake("all_ones", 1'b0);
    endtask

    task automatic test_alternating();
        for (int k = 0; k < NSTR; k++) stream[k] = (k % 2 == 1);
        convert(0, "alternating", 1'b0);
        checks++;
        if (result !== 8'd128) begin
            fails++;
            $display("FAIL alternating literal: result=%0d, expected 128", result);
        end
        handshake("alternating", 1'b0);
    endtask

    task automatic test_quarter();
        int pos [WIN];
        int s, j, t;
        s = 3;
        for (int k = 0; k < NSTR; k++) stream[k] = 1'($urandom);
        for (int k = s + 1; k <= s + WIN; k++) stream[k] = 1'b0;
        for (int k = 0; k < WIN; k++) pos[k] = k;
        for (int k = WIN - 1; k > 0; k--) begin
            j = $urandom_range(k, 0);
            t = pos[k]; pos[k] = pos[j]; pos[j] = t;
        end
        for (int k = 0; k < 64; k++) stream[s + 1 + pos[k]] = 1'b1;
        convert(s, "quarter", 1'b0);
        checks++;
        if (result !== 8'd64) begin
            fails++;
            $display("FAIL quarter literal: result=%0d, expected 64", result);
        end
        handshake("quarter", 1'b0);
    endtask

    task automatic test_skip();
        for (int k = 0; k < NSTR; k++) stream[k] = (k >= 1 && k <= 5);
        convert(5, "skip5", 1'b0);
        handshake("skip5", 1'b0);
    endtask

    task automatic test_random();
        int s, density;
        for (int r = 0; r < 4; r++) begin
            s = $urandom_range(15, 0);
            density = $urandom_range(100, 0);
            for (int k = 0; k < NSTR; k++) stream[k] = ($urandom_range(99, 0) < density);
            convert(s, $sformatf("random%0d", r), 1'b0);
            handshake($sformatf("random%0d", r), 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < NSTR; k++) stream[k] = 1'($urandom);
        convert(2, "backpressure", 1'b1);
        for (int i = 0; i < 10; i++) begin
            start = (i % 3 == 0);
            @(posedge clk); #1;
            start = 1'b0;
            checks++;
            if (result_valid !== 1'b1 || busy !== 1'b1 || result !== exp_result || saturated !== exp_sat) begin
                fails++;
                $display("FAIL hold cycle %0d: valid=%0b busy=%0b result=%0d sat=%0b, expected 1 1 %0d %0b",
                         i, result_valid, busy, result, saturated, exp_result, exp_sat);
            end
        end
        handshake("backpressure", 1'b1);
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL restart_after_handshake: busy=%0b, expected 0", busy);
        end
        for (int k = 0; k < NSTR; k++) stream[k] = (k % 4 == 0);
        convert(0, "fresh", 1'b0);
        handshake("fresh", 1'b0);
    endtask

    task automatic test_reset_mid_acc();
        for (int k = 0; k < NSTR; k++) stream[k] = 1'b1;
        start  = 1'b1;
        skip   = '0;
        bit_in = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (100) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || result !== '0 || result_valid !== 1'b0 || saturated !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: busy=%0b result=%0d valid=%0b sat=%0b, expected all 0",
                     busy, result, result_valid, saturated);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        $display("async reset mid-ACC applied");
        for (int k = 0; k < NSTR; k++) stream[k] = 1'b0;
        convert(0, "post_reset", 1'b0);
        handshake("post_reset", 1'b0);
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_alternating();
        test_quarter();
        test_skip();
        test_random();
        test_back_to_back();
        test_reset_mid_acc();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/sc_stream_decoder.md
Name: sc_stream_decoder

Overview:
- Stochastic-to-binary converter at the output end of the stochastic arithmetic units, such as the correlated divider and its counter-regeneration wrapper.
- Consumes a unipolar bitstream and discards a programmable number of leading settling cycles.
- Counts ones over a fixed window of 2^WIDTH cycles.
- Presents the count as a WIDTH-bit binary value through a valid/ready handshake.
- Used by benches and by on-chip readback to recover quotient and product values.

Parameters:
- WIDTH, 8, result width; observation window is 2^WIDTH cycles.
- SKIP_W, 4, width of the settling-skip count (0 to 2^SKIP_W-1 cycles).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous reset, active low
- start  input  1  begin a conversion; honoured only in IDLE
- skip  input  SKIP_W  leading cycles to discard; sampled on the accepted start edge
- bit_in  input  1  stochastic bitstream under measurement
- busy  output  1  high in SKIP, ACC and HOLD
- result  output  WIDTH  ones count of the last completed window, saturated
- saturated  output  1  last window contained 2^WIDTH ones; qualified by result_valid
- result_valid  output  1  result available
- result_ready  input  1  consumer accepts result

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state IDLE; busy, result, saturated and result_valid all 0; internal counters 0.
- Asserting rst_n low at any time, mid-conversion included, forces these values immediately and aborts any conversion.
- State IDLE:
  - On an edge with start=1, latch skip into skip_cnt and clear ones_cnt (WIDTH+1 bits) and win_cnt (WIDTH+1 bits).
  - Next state is SKIP if skip!=0, otherwise ACC.
  - bit_in is ignored.
- State SKIP:
  - bit_in is ignored; skip_cnt decrements each edge.
  - The edge on which skip_cnt==1 moves to ACC, so exactly skip cycles are discarded.
- State ACC:
  - Each edge: ones_cnt += bit_in and win_cnt += 1.
  - The edge that samples the 2^WIDTH-th bit does all of the following on that same edge:
    - registers result = (ones_cnt_next == 2^WIDTH) ? 2^WIDTH-1 : ones_cnt_next[WIDTH-1:0];
    - registers saturated = (ones_cnt_next == 2^WIDTH);
    - sets result_valid=1 and enters HOLD.
- State HOLD:
  - result, saturated and result_valid stay stable until an edge with result_ready=1.
  - On that edge result_valid clears and the state returns to IDLE; busy drops on the same edge.
  - result and saturated keep their last values after the handshake until the next window completes.
- Latency: bit_in is first counted on the edge skip+1 after the start edge. result_valid asserts on edge skip+2^WIDTH after the start edge.
- start while busy (SKIP, ACC or HOLD) is ignored, including start coincident with the HOLD handshake edge; a new start must arrive while in IDLE.
- result_ready outside HOLD has no effect.
- Arithmetic:
  - The counters never wrap: the window ends exactly when win_cnt reaches 2^WIDTH.
  - ones_cnt reaches at most 2^WIDTH, and that case is the only saturation case.
- skip changes after the start edge have no effect on the running conversion.

Test Plan:
- Reset: hold rst_n=0 then release with start=0 -> busy=0, result=0, result_valid=0, saturated=0; state stays IDLE for 20 cycles.
- WIDTH=8, skip=0, bit_in=1 constant, start pulse -> result_valid rises 256 edges after start; result=255, saturated=1; busy high throughout.
- WIDTH=8, skip=0, bit_in alternating 1,0 starting with 1 -> result=128, saturated=0.
- Repeat with bit_in=1 on exactly 64 of 256 cycles (random positions) -> result=64.
- WIDTH=8, skip=5, bit_in=1 for the first 5 cycles after start then 0 -> result=0, result_valid at start+261 edges.
- Backpressure: hold result_ready=0 for 10 cycles after result_valid, pulsing start during both ACC and HOLD -> result, saturated and result_valid unchanged and no restart. Then result_ready=1 for one edge -> valid clears, busy=0, IDLE; a following start begins a fresh window.
- Reset mid-ACC (after 100 samples): assert rst_n=0 asynchronously -> all outputs 0 before the next clk edge. Release, start with bit_in=0 -> result=0 after 256 edges with no residue from the aborted window.
